pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 4, shall set the multiply busy length in cycles (legal 1..63).
REQ-002 Parameter DIV_CYCLES, default 32, shall set the divide busy length in cycles (legal 1..63).
REQ-003 The block shall have one clock; reset is asynchronous and active-high.
REQ-004 Ports shall be:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-high reset
- Rs_D, Rt_D  in  5 each  decode-stage source registers
- Rs_E, Rt_E  in  5 each  execute-stage source registers
- WriteReg_E, WriteReg_M, WriteReg_W  in  5 each  destination register per stage
- RegWrite_E, RegWrite_M, RegWrite_W  in  1 each  register-write enable per stage
- MemtoReg_E, MemtoReg_M  in  1 each  load in stage
- Branch_D, PCSrc_D, Jump_D  in  1 each  branch in D, branch taken, jump in D
- MulDiv_D, MfHiLo_D  in  1 each  D holds mult/div, D reads HI/LO
- MulDiv_E, IsDiv_E  in  1 each  E holds mult/div, op is divide
- StallF, StallD  out  1 each  hold PC and IF/ID register
- FlushD, FlushE  out  1 each  clear IF/ID, clear ID/EX
- ForwardA_D, ForwardB_D  out  1 each  forward M-stage result to D comparator
- ForwardA_E, ForwardB_E  out  2 each  ALU operand select (00 reg, 01 W, 10 M)
- MdBusy, MdDone  out  1 each  mult/div unit busy, one-cycle completion pulse

Function
REQ-005 A register index of 0 shall never match for forwarding or stall detection.
REQ-006 ForwardA_E shall be 10 when RegWrite_M and WriteReg_M==Rs_E; else 01 when RegWrite_W and WriteReg_W==Rs_E; else 00; M shall take priority over W.
REQ-007 ForwardB_E shall follow REQ-006 using Rt_E.
REQ-008 ForwardA_D (ForwardB_D) shall be 1 iff RegWrite_M and WriteReg_M==Rs_D (Rt_D).
REQ-009 lwstall shall be MemtoReg_E and WriteReg_E matching Rs_D or Rt_D.
REQ-010 branchstall shall be Branch_D and either (RegWrite_E, WriteReg_E matching Rs_D/Rt_D) or (MemtoReg_M, WriteReg_M matching Rs_D/Rt_D).
REQ-011 mdstall shall be (MulDiv_D or MfHiLo_D) and (state==BUSY or (state!=BUSY and MulDiv_E)).
REQ-012 StallF = StallD = FlushE = lwstall | branchstall | mdstall, combinationally.
REQ-013 FlushD shall be (PCSrc_D | Jump_D) and not StallD.
REQ-014 Mult/div sequencer FSM shall have states IDLE, BUSY, DONE, plus a 6-bit down-counter.
REQ-015 IDLE or DONE with MulDiv_E: next state BUSY, counter loaded with (IsDiv_E ? DIV_CYCLES : MULT_CYCLES) - 1.
REQ-016 IDLE without MulDiv_E: remain IDLE; DONE without MulDiv_E: next state IDLE.
REQ-017 BUSY: counter==0 -> DONE, else decrement; BUSY shall last exactly the configured cycle count.
REQ-018 MulDiv_E asserted while BUSY shall be ignored; mdstall guarantees it does not occur in legal flow.
REQ-019 MdBusy shall be 1 iff state==BUSY; MdDone shall be 1 iff state==DONE; both are registered-state decodes.
REQ-020 For MulDiv_E in cycle t from IDLE: MdBusy high cycles t+1..t+N, MdDone high cycle t+N+1.
REQ-021 HI/LO shall be valid from the DONE cycle onward; MfHiLo_D in DONE shall not stall.

Reset
REQ-022 reset shall force state IDLE and counter 0 immediately, without waiting for clk; MdBusy=0, MdDone=0.
REQ-023 Reset during BUSY shall abort the operation; no MdDone pulse shall follow.
REQ-024 With reset asserted, combinational outputs shall still follow REQ-006..013 from inputs, with mdstall terms derived from state IDLE.

Verification
REQ-025 RegWrite_M=1, WriteReg_M=5, RegWrite_W=1, WriteReg_W=5, Rs_E=5 -> ForwardA_E=10; with WriteReg_M=0 instead -> ForwardA_E=01.
REQ-026 MemtoReg_E=1, WriteReg_E=8, Rt_D=8 -> StallF=StallD=FlushE=1, FlushD=0; with WriteReg_E=0 -> all 0.
REQ-027 Branch_D=1, RegWrite_E=1, WriteReg_E=3, Rs_D=3, PCSrc_D=1 -> StallD=1, FlushD=0.
REQ-028 MulDiv_E=1, IsDiv_E=0 at cycle 0 -> MdBusy cycles 1..4, MdDone cycle 5; MfHiLo_D held high stalls cycles 0..4 only.
REQ-029 Divide started, reset pulsed at cycle 10 -> MdBusy=0 asynchronously, no MdDone; back-to-back MulDiv_E in DONE -> direct re-entry to BUSY.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: forwarding, stall/flush control and mult/div busy sequencer for a 5-stage pipeline
module pipeline_hazard_ctrl #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] Rs_D,
  input  logic [4:0] Rt_D,
  input  logic [4:0] Rs_E,
  input  logic [4:0] Rt_E,
  input  logic [4:0] WriteReg_E,
  input  logic [4:0] WriteReg_M,
  input  logic [4:0] WriteReg_W,
  input  logic       RegWrite_E,
  input  logic       RegWrite_M,
  input  logic       RegWrite_W,
  input  logic       MemtoReg_E,
  input  logic       MemtoReg_M,
  input  logic       Branch_D,
  input  logic       PCSrc_D,
  input  logic       Jump_D,
  input  logic       MulDiv_D,
  input  logic       MfHiLo_D,
  input  logic       MulDiv_E,
  input  logic       IsDiv_E,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushD,
  output logic       FlushE,
  output logic       ForwardA_D,
  output logic       ForwardB_D,
  output logic [1:0] ForwardA_E,
  output logic [1:0] ForwardB_E,
  output logic       MdBusy,
  output logic       MdDone
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [5:0] cnt;
  logic [5:0] load;
  logic lwstall, branchstall, mdstall, stall;
  // register 0 is hardwired, so it never carries a dependency
  function automatic logic hit(input logic [4:0] a, input logic [4:0] b);
    return a != 5'd0 && a == b;
  endfunction
  assign ForwardA_E = (RegWrite_M && hit(WriteReg_M, Rs_E)) ? 2'b10 :
                      (RegWrite_W && hit(WriteReg_W, Rs_E)) ? 2'b01 : 2'b00;
  assign ForwardB_E = (RegWrite_M && hit(WriteReg_M, Rt_E)) ? 2'b10 :
                      (RegWrite_W && hit(WriteReg_W, Rt_E)) ? 2'b01 : 2'b00;
  assign ForwardA_D = RegWrite_M && hit(WriteReg_M, Rs_D);
  assign ForwardB_D = RegWrite_M && hit(WriteReg_M, Rt_D);
  assign lwstall = MemtoReg_E && (hit(WriteReg_E, Rs_D) || hit(WriteReg_E, Rt_D));
  assign branchstall = Branch_D &&
    ((RegWrite_E && (hit(WriteReg_E, Rs_D) || hit(WriteReg_E, Rt_D))) ||
     (MemtoReg_M && (hit(WriteReg_M, Rs_D) || hit(WriteReg_M, Rt_D))));
  assign mdstall = (MulDiv_D || MfHiLo_D) && (state == BUSY || MulDiv_E);
  assign stall = lwstall || branchstall || mdstall;
  assign StallF = stall;
  assign StallD = stall;
  assign FlushE = stall;
  assign FlushD = (PCSrc_D || Jump_D) && !stall;
  assign load = IsDiv_E ? 6'(DIV_CYCLES - 1) : 6'(MULT_CYCLES - 1);
  // a new op may start from DONE, giving back-to-back issue without an idle gap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= 6'd0;
      MdBusy <= 1'b0;
      MdDone <= 1'b0;
    end else if (state != BUSY && MulDiv_E) begin
      state <= BUSY;
      cnt <= load;
      MdBusy <= 1'b1;
      MdDone <= 1'b0;
    end else if (state == BUSY && cnt == 6'd0) begin
      state <= DONE;
      MdBusy <= 1'b0;
      MdDone <= 1'b1;
    end else if (state == BUSY) begin
      cnt <= cnt - 6'd1;
    end else begin
      state <= IDLE;
      MdDone <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and randomized checks of hazard outputs and mult/div timing
module tb_pipeline_hazard_ctrl;
  logic clk = 0, reset = 1;
  logic [4:0] Rs_D, Rt_D, Rs_E, Rt_E, WriteReg_E, WriteReg_M, WriteReg_W;
  logic RegWrite_E, RegWrite_M, RegWrite_W, MemtoReg_E, MemtoReg_M;
  logic Branch_D, PCSrc_D, Jump_D, MulDiv_D, MfHiLo_D, MulDiv_E, IsDiv_E;
  logic StallF, StallD, FlushD, FlushE, ForwardA_D, ForwardB_D, MdBusy, MdDone;
  logic [1:0] ForwardA_E, ForwardB_E;
  wire [9:0] obs = {StallF, StallD, FlushD, FlushE, ForwardA_D, ForwardB_D, ForwardA_E, ForwardB_E};
  int total = 0, bad = 0;
  int cyc = 0, bstart = 1, bend = 0, dcycle = -1;

  pipeline_hazard_ctrl dut (
    .clk(clk), .reset(reset), .Rs_D(Rs_D), .Rt_D(Rt_D), .Rs_E(Rs_E), .Rt_E(Rt_E),
    .WriteReg_E(WriteReg_E), .WriteReg_M(WriteReg_M), .WriteReg_W(WriteReg_W),
    .RegWrite_E(RegWrite_E), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
    .MemtoReg_E(MemtoReg_E), .MemtoReg_M(MemtoReg_M), .Branch_D(Branch_D),
    .PCSrc_D(PCSrc_D), .Jump_D(Jump_D), .MulDiv_D(MulDiv_D), .MfHiLo_D(MfHiLo_D),
    .MulDiv_E(MulDiv_E), .IsDiv_E(IsDiv_E), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .FlushE(FlushE), .ForwardA_D(ForwardA_D), .ForwardB_D(ForwardB_D),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .MdBusy(MdBusy), .MdDone(MdDone)
  );

  always #5 clk = ~clk;

  function automatic bit mbusy();
    return cyc >= bstart && cyc <= bend;
  endfunction

  function automatic bit dep(input logic [4:0] a, input logic [4:0] b);
    return a != 0 && a == b;
  endfunction

  function automatic logic [1:0] fwd_e(input logic [4:0] r);
    if (RegWrite_M && dep(WriteReg_M, r)) return 2'b10;
    if (RegWrite_W && dep(WriteReg_W, r)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [9:0] exp_comb();
    bit busy, lw, br, md, st;
    busy = !reset && mbusy();
    lw = MemtoReg_E && (dep(WriteReg_E, Rs_D) || dep(WriteReg_E, Rt_D));
    br = Branch_D && ((RegWrite_E && (dep(WriteReg_E, Rs_D) || dep(WriteReg_E, Rt_D))) ||
                      (MemtoReg_M && (dep(WriteReg_M, Rs_D) || dep(WriteReg_M, Rt_D))));
    md = (MulDiv_D || MfHiLo_D) && (busy || MulDiv_E);
    st = lw || br || md;
    return {st, st, (PCSrc_D || Jump_D) && !st, st,
            RegWrite_M && dep(WriteReg_M, Rs_D), RegWrite_M && dep(WriteReg_M, Rt_D),
            fwd_e(Rs_E), fwd_e(Rt_E)};
  endfunction

  task automatic clear_inputs();
    {Rs_D, Rt_D, Rs_E, Rt_E, WriteReg_E, WriteReg_M, WriteReg_W} = '0;
    {RegWrite_E, RegWrite_M, RegWrite_W, MemtoReg_E, MemtoReg_M} = '0;
    {Branch_D, PCSrc_D, Jump_D, MulDiv_D, MfHiLo_D, MulDiv_E, IsDiv_E} = '0;
  endtask

  task automatic rand_inputs(input int md_pct);
    Rs_D = 5'($urandom_range(0, 3)); Rt_D = 5'($urandom_range(0, 3));
    Rs_E = 5'($urandom_range(0, 3)); Rt_E = 5'($urandom_range(0, 3));
    WriteReg_E = 5'($urandom_range(0, 3)); WriteReg_M = 5'($urandom_range(0, 3));
    WriteReg_W = 5'($urandom_range(0, 3));
    {RegWrite_E, RegWrite_M, RegWrite_W, MemtoReg_E, MemtoReg_M} = 5'($urandom);
    {Branch_D, PCSrc_D, Jump_D, MulDiv_D, MfHiLo_D, IsDiv_E} = 6'($urandom);
    MulDiv_E = $urandom_range(0, 99) < md_pct;
  endtask

  task automatic clear_model();
    bstart = 1; bend = 0; dcycle = -1;
  endtask

  task automatic tick();
    int n;
    if (reset) clear_model();
    else if (MulDiv_E && !mbusy()) begin
      n = IsDiv_E ? 32 : 4;
      bstart = cyc + 1; bend = cyc + n; dcycle = cyc + n + 1;
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    reset = 1;
    clear_model();
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    #1;
    total++;
    if (MdBusy !== 0 || MdDone !== 0) begin
      bad++; $display("FAIL reset_md: busy=%b done=%b want 0 0", MdBusy, MdDone);
    end
    total++;
    if (obs !== 10'd0) begin bad++; $display("FAIL reset_comb: got %b want 0", obs); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rand_inputs(50);
      #1;
      total++;
      if (obs !== exp_comb() || MdBusy !== 0) begin
        bad++; $display("FAIL reset_held_comb: got %b busy=%b want %b busy=0", obs, MdBusy, exp_comb());
      end
    end
    do_reset();
  endtask

  task automatic test_forwarding();
    @(negedge clk);
    clear_inputs();
    RegWrite_M = 1; WriteReg_M = 5; RegWrite_W = 1; WriteReg_W = 5; Rs_E = 5;
    #1;
    total++;
    if (ForwardA_E !== 2'b10) begin bad++; $display("FAIL fwd_m_prio: got %b want 10", ForwardA_E); end
    WriteReg_M = 0;
    #1;
    total++;
    if (ForwardA_E !== 2'b01) begin bad++; $display("FAIL fwd_w: got %b want 01", ForwardA_E); end
    RegWrite_W = 1; WriteReg_W = 0; Rs_E = 0;
    #1;
    total++;
    if (ForwardA_E !== 2'b00) begin bad++; $display("FAIL fwd_r0: got %b want 00", ForwardA_E); end
    clear_inputs();
  endtask

  task automatic test_stalls();
    @(negedge clk);
    clear_inputs();
    MemtoReg_E = 1; WriteReg_E = 8; Rt_D = 8;
    #1;
    total++;
    if ({StallF, StallD, FlushE, FlushD} !== 4'b1110) begin
      bad++; $display("FAIL lwstall: got %b want 1110", {StallF, StallD, FlushE, FlushD});
    end
    WriteReg_E = 0;
    #1;
    total++;
    if ({StallF, StallD, FlushE, FlushD} !== 4'b0000) begin
      bad++; $display("FAIL lwstall_r0: got %b want 0000", {StallF, StallD, FlushE, FlushD});
    end
    clear_inputs();
    Branch_D = 1; RegWrite_E = 1; WriteReg_E = 3; Rs_D = 3; PCSrc_D = 1;
    #1;
    total++;
    if (StallD !== 1 || FlushD !== 0) begin
      bad++; $display("FAIL branchstall: stalld=%b flushd=%b want 1 0", StallD, FlushD);
    end
    Rs_D = 4;
    #1;
    total++;
    if (StallD !== 0 || FlushD !== 1) begin
      bad++; $display("FAIL branch_taken: stalld=%b flushd=%b want 0 1", StallD, FlushD);
    end
    clear_inputs();
  endtask

  task automatic test_mult_timing();
    bit eb, ed, es;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      MfHiLo_D = 1;
      MulDiv_E = (c == 0);
      IsDiv_E = 0;
      #1;
      eb = c >= 1 && c <= 4; ed = c == 5; es = c <= 4;
      total++;
      if (MdBusy !== eb || MdDone !== ed || StallD !== es) begin
        bad++; $display("FAIL mult_timing c=%0d: busy=%b done=%b stall=%b want %b %b %b",
                        c, MdBusy, MdDone, StallD, eb, ed, es);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    bit eb, ed;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      MulDiv_E = (c == 0 || c == 5);
      IsDiv_E = 0;
      #1;
      eb = (c >= 1 && c <= 4) || (c >= 6 && c <= 9); ed = c == 5 || c == 10;
      total++;
      if (MdBusy !== eb || MdDone !== ed) begin
        bad++; $display("FAIL back_to_back c=%0d: busy=%b done=%b want %b %b", c, MdBusy, MdDone, eb, ed);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_reset_abort();
    int errs = 0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      MulDiv_E = (c == 0);
      IsDiv_E = 1;
      tick();
    end
    #1;
    total++;
    if (MdBusy !== 1) begin bad++; $display("FAIL div_busy_before_abort: got %b want 1", MdBusy); end
    @(negedge clk);
    clear_inputs();
    reset = 1;
    clear_model();
    #1;
    total++;
    if (MdBusy !== 0 || MdDone !== 0) begin
      bad++; $display("FAIL async_abort: busy=%b done=%b want 0 0", MdBusy, MdDone);
    end
    @(negedge clk);
    reset = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (MdBusy !== 0 || MdDone !== 0) errs++;
      tick();
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL no_done_after_abort: %0d bad cycles want 0", errs); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rand_inputs(15);
      #1;
      total++;
      if (obs !== exp_comb() || MdBusy !== mbusy() || MdDone !== (cyc == dcycle)) begin
        bad++; $display("FAIL random i=%0d: out=%b busy=%b done=%b want %b %b %b",
                        i, obs, MdBusy, MdDone, exp_comb(), mbusy(), cyc == dcycle);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_stalls();
    test_mult_timing();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
